// File: rtl/lcd_pkg.sv
// HD44780 command constants, FSM/phase enums and character helpers shared by the hex display driver.
// Pure definitions: no timing, no flow control.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] LCD_ADDR_L1      = 8'h80;

  localparam logic [3:0] INIT_LAST_IDX = 4'd5;
  localparam logic [3:0] DRAW_LAST_IDX = 4'd8;

  typedef enum logic [1:0] {ST_PWR_WAIT, ST_INIT, ST_IDLE, ST_DRAW} lcd_state_e;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_WAIT} wr_phase_e;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = LCD_FUNC_8BIT_2L;
      3'd3:             cmd = LCD_DISP_ON;
      3'd4:             cmd = LCD_CLEAR;
      default:          cmd = LCD_ENTRY_INC;
    endcase
    return cmd;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One LCD write: SETUP (1 cycle), PULSE (E cycles, en=1), WAIT (cmd or clear settle); data/rs held throughout.
// A new start is accepted when idle or in the final WAIT cycle (done), so writes chain with no gap.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYCLES    = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  wr_phase_e   phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic        long_q, long_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        ready;

  assign done  = (phase_q == PH_WAIT) && (cnt_q == '0);
  assign ready = (phase_q == PH_IDLE) || done;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    case (phase_q)
      PH_SETUP: begin
        phase_d = PH_PULSE;
        cnt_d   = 32'(E_PULSE_CYCLES - 1);
        en_d    = 1'b1;
      end
      PH_PULSE: begin
        if (cnt_q == '0) begin
          phase_d = PH_WAIT;
          cnt_d   = long_q ? 32'(CLEAR_WAIT_CYCLES - 1) : 32'(CMD_WAIT_CYCLES - 1);
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      PH_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 32'd1;
        else             phase_d = PH_IDLE;
      end
      default: ;
    endcase
    // A chained start overrides the return to idle at the end of WAIT.
    if (start && ready) begin
      phase_d = PH_SETUP;
      rs_d    = rs;
      data_d  = data;
      long_d  = long_wait;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_hex_display.sv
// Power-on init of an HD44780 in 8-bit mode, then draws a 32-bit word as 8 hex chars on line 1.
// Update in IDLE starts the first write 1 cycle later; updates while busy are kept (latest wins) and redrawn.
module lcd_hex_display
  import lcd_pkg::*;
#(
  parameter int unsigned POWER_ON_CYCLES   = 750000,
  parameter int unsigned E_PULSE_CYCLES    = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        update,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en
);

  lcd_state_e  state_q, state_d;
  logic [31:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        wr_start, wr_rs, wr_long, wr_done;
  logic [7:0]  wr_data;
  logic        begin_draw;
  logic [31:0] next_val;

  assign next_val = update ? value : (pending_q ? shadow_q : value);

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    wr_start   = 1'b0;
    wr_rs      = 1'b0;
    wr_data    = 8'h00;
    wr_long    = 1'b0;
    begin_draw = 1'b0;

    if (update && state_q != ST_IDLE) begin
      pending_d = 1'b1;
      shadow_d  = value;
    end

    case (state_q)
      ST_PWR_WAIT: begin
        if (pwr_cnt_q == '0) begin
          state_d  = ST_INIT;
          idx_d    = 4'd0;
          wr_start = 1'b1;
          wr_data  = init_cmd(3'd0);
        end else begin
          pwr_cnt_d = pwr_cnt_q - 32'd1;
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          if (idx_q == INIT_LAST_IDX) begin
            begin_draw = 1'b1;
          end else begin
            idx_d    = idx_q + 4'd1;
            wr_start = 1'b1;
            wr_data  = init_cmd(idx_d[2:0]);
            wr_long  = (wr_data == LCD_CLEAR);
          end
        end
      end
      ST_IDLE: begin
        if (update) begin
          state_d  = ST_DRAW;
          idx_d    = 4'd0;
          cur_d    = value;
          wr_start = 1'b1;
          wr_data  = LCD_ADDR_L1;
        end
      end
      ST_DRAW: begin
        if (wr_done) begin
          if (idx_q == DRAW_LAST_IDX) begin
            if (pending_q || update) begin_draw = 1'b1;
            else                     state_d    = ST_IDLE;
          end else begin
            // cur_q shifts left so the next digit is always its top nibble.
            idx_d    = idx_q + 4'd1;
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = hex_char(cur_q[31:28]);
            cur_d    = {cur_q[27:0], 4'h0};
          end
        end
      end
      default: ;
    endcase

    if (begin_draw) begin
      state_d   = ST_DRAW;
      idx_d     = 4'd0;
      cur_d     = next_val;
      pending_d = 1'b0;
      wr_start  = 1'b1;
      wr_rs     = 1'b0;
      wr_data   = LCD_ADDR_L1;
      wr_long   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_PWR_WAIT;
      pwr_cnt_q <= 32'(POWER_ON_CYCLES - 1);
      idx_q     <= 4'd0;
      cur_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  lcd_bus_writer #(
    .E_PULSE_CYCLES   (E_PULSE_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_writer (
    .clock    (clock),
    .reset    (reset),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_wait(wr_long),
    .done     (wr_done),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data)
  );

  assign busy   = (state_q != ST_IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Bench for lcd_hex_display: a strobe monitor captures every LCD write, compared against a byte-stream model.
// Small timing parameters keep the run short.
module tb_lcd_hex_display;

  localparam int PON = 20;
  localparam int EP  = 2;
  localparam int CW  = 4;
  localparam int CLW = 8;
  localparam int WR_CYC = 1 + EP + CW;

  logic        clock;
  logic        reset;
  logic [31:0] value;
  logic        update;
  logic        busy;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;

  lcd_hex_display #(
    .POWER_ON_CYCLES  (PON),
    .E_PULSE_CYCLES   (EP),
    .CMD_WAIT_CYCLES  (CW),
    .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .value   (value),
    .update  (update),
    .busy    (busy),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         rise_q[$];
  int         fall_q[$];
  bit         mon_on = 1'b0;
  int         rw_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: records {rs,data} and rise cycle of each enable pulse, plus busy falling edges.
  initial begin
    logic       prev_en = 1'b0;
    logic       prev_rs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_busy = 1'b1;
    int         hi_cnt = 0;
    logic       stab = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (lcd_en && !prev_en) begin
          got_q.push_back({lcd_rs, lcd_data});
          rise_q.push_back(cyc);
          hi_cnt = 1;
          stab   = (lcd_data === prev_data) && (lcd_rs === prev_rs);
        end else if (lcd_en) begin
          hi_cnt++;
          stab = stab && (lcd_data === prev_data) && (lcd_rs === prev_rs);
        end else if (prev_en) begin
          stab = stab && (lcd_data === prev_data) && (lcd_rs === prev_rs);
          check("en_high_cycles", 32'(hi_cnt), 32'(EP));
          check("bus_stable", {31'd0, stab}, 32'd1);
        end
        if (!busy && prev_busy) fall_q.push_back(cyc);
      end
      prev_en   = lcd_en;
      prev_rs   = lcd_rs;
      prev_data = lcd_data;
      prev_busy = busy;
    end
  end

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  task automatic model_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic model_draw(input logic [31:0] v);
    int nib;
    exp_q.push_back({1'b0, 8'h80});
    for (int k = 0; k < 8; k++) begin
      nib = int'((v >> (28 - 4 * k)) & 32'hF);
      exp_q.push_back({1'b1, 8'((nib < 10) ? (8'd48 + nib) : (8'd55 + nib))});
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && fall_q.size() == 0; i++) @(posedge clock);
    #1;
    check({tag, "_idle_reached"}, {31'd0, fall_q.size() > 0}, 32'd1);
  endtask

  task automatic pulse_update(input logic [31:0] v);
    value  = v;
    update = 1'b1;
    @(posedge clock);
    #1;
    update = 1'b0;
  endtask

  task automatic verify(input string tag);
    int n;
    int gap;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      if (i > 0) begin
        gap = 1 + EP + ((exp_q[i-1] == 9'h001) ? CLW : CW);
        check($sformatf("%s_gap%0d", tag, i), 32'(rise_q[i] - rise_q[i-1]), 32'(gap));
      end
    end
    check({tag, "_busy_falls"}, 32'(fall_q.size()), 32'd1);
    if (fall_q.size() > 0 && got_q.size() >= 9)
      check({tag, "_busy_time"}, 32'(fall_q[0] - rise_q[got_q.size() - 9]), 32'(9 * WR_CYC - 1));
  endtask

  initial begin
    int          rel_cyc;
    int          upd_cyc;
    int          r8;
    logic [31:0] v;
    logic [31:0] v2;

    reset  = 1'b0;
    update = 1'b0;
    value  = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_en",   {31'd0, lcd_en}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_rs",   {31'd0, lcd_rs}, 32'd0);
    check("rst_rw",   {31'd0, lcd_rw}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // Power-up with value 0 held: init commands then automatic draw of "00000000".
    clear_all();
    mon_on  = 1'b1;
    rel_cyc = cyc;
    reset   = 1'b1;
    model_init();
    model_draw(32'h0);
    wait_idle("init", 1000);
    if (rise_q.size() > 0) check("pwr_wait_first_rise", 32'(rise_q[0] - rel_cyc), 32'(PON + 1));
    verify("init");

    // Directed draw of DEADBEEF from IDLE.
    clear_all();
    repeat (2) @(posedge clock);
    #1;
    upd_cyc = cyc;
    pulse_update(32'hDEADBEEF);
    model_draw(32'hDEADBEEF);
    wait_idle("dead", 500);
    if (rise_q.size() > 0) check("dead_latency", 32'(rise_q[0] - upd_cyc), 32'd2);
    verify("dead");

    // Random draws from IDLE.
    for (int t = 0; t < 4; t++) begin
      clear_all();
      repeat ($urandom_range(1, 6)) @(posedge clock);
      #1;
      v = $urandom;
      upd_cyc = cyc;
      pulse_update(v);
      model_draw(v);
      wait_idle($sformatf("rnd%0d", t), 500);
      if (rise_q.size() > 0) check($sformatf("rnd%0d_latency", t), 32'(rise_q[0] - upd_cyc), 32'd2);
      verify($sformatf("rnd%0d", t));
    end

    // Two updates during a draw: the draw completes unchanged, then one redraw of the latest.
    clear_all();
    @(posedge clock);
    #1;
    pulse_update(32'h12345678);
    repeat ($urandom_range(3, 30)) @(posedge clock);
    #1;
    pulse_update(32'hAAAAAAAA);
    repeat ($urandom_range(1, 10)) @(posedge clock);
    #1;
    pulse_update(32'h0F0F0F0F);
    model_draw(32'h12345678);
    model_draw(32'h0F0F0F0F);
    wait_idle("pend", 1000);
    verify("pend");

    // Update in the exact cycle the draw's final WAIT completes.
    clear_all();
    @(posedge clock);
    #1;
    v  = $urandom;
    v2 = $urandom;
    pulse_update(v);
    for (int i = 0; i < 300 && got_q.size() < 9; i++) @(posedge clock);
    #1;
    check("edge_ninth_strobe_seen", {31'd0, got_q.size() >= 9}, 32'd1);
    if (got_q.size() >= 9) begin
      r8 = rise_q[8];
      for (int i = 0; i < 50 && cyc < r8 + WR_CYC - 2; i++) begin
        @(posedge clock);
        #1;
      end
      pulse_update(v2);
    end
    model_draw(v);
    model_draw(v2);
    wait_idle("edge", 1000);
    verify("edge");

    // Reset asserted during the enable pulse of a data write.
    clear_all();
    @(posedge clock);
    #1;
    v = $urandom;
    pulse_update(v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #1;
      if (got_q.size() >= 3 && lcd_en) break;
    end
    check("mid_pulse_en", {31'd0, lcd_en}, 32'd1);
    check("mid_pulse_rs", {31'd0, lcd_rs}, 32'd1);
    mon_on = 1'b0;
    reset  = 1'b0;
    #1;
    check("arst_en",   {31'd0, lcd_en}, 32'd0);
    check("arst_data", {24'd0, lcd_data}, 32'd0);
    check("arst_rs",   {31'd0, lcd_rs}, 32'd0);
    check("arst_rw",   {31'd0, lcd_rw}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd1);
    clear_all();
    repeat (3) @(posedge clock);
    #1;
    mon_on  = 1'b1;
    rel_cyc = cyc;
    reset   = 1'b1;
    model_init();
    model_draw(v);
    wait_idle("reinit", 1000);
    if (rise_q.size() > 0) check("reinit_first_rise", 32'(rise_q[0] - rel_cyc), 32'(PON + 1));
    verify("reinit");

    check("rw_never_high", 32'(rw_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
